// File: rtl/serdes_pkg.sv
// Shared types and constants for the serial frame receiver.
package serdes_pkg;

    // Receiver framing states
    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } rx_state_t;

    // 8 data bits followed by one even-parity bit
    localparam int FRAME_BITS = 9;

    // Default alignment byte
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    // Even parity bit for a data byte: makes the total number of ones even
    function automatic logic even_par(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/serdes_frame_rx.sv
// Serial frame receiver: hunts for a sync word, confirms alignment, then
// delivers parity-checked 8-bit words and drops lock on repeated errors.
import serdes_pkg::*;

module serdes_frame_rx #(
    parameter logic [7:0] SYNC_WORD = SYNC_DEFAULT,
    parameter int         CONFIRM   = 2,
    parameter int         ERR_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ser_in,
    input  logic       ser_en,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       sync_seen,
    output logic       par_err,
    output logic       locked,
    output logic [7:0] err_cnt
);

    localparam logic [8:0] SYNC_FRAME = {SYNC_WORD, even_par(SYNC_WORD)};
    localparam logic [3:0] LAST_BIT   = 4'(FRAME_BITS - 1);
    // Sync frames still needed in VERIFY once the hunt match has counted as one
    localparam logic [2:0] VERIFY_SYNCS = 3'(CONFIRM - 1);
    localparam logic [3:0] ERR_LIMIT_W  = 4'(ERR_LIMIT);

    rx_state_t  state;
    logic [8:0] sr;
    logic [3:0] bit_cnt;
    logic [2:0] conf_cnt;
    logic [3:0] err_run;

    logic [8:0] sr_next;
    logic       frame_done;
    logic       par_ok;
    logic       is_sync_frame;

    // Next shift value and frame qualifiers, all judged on the incoming bit
    always_comb begin
        sr_next       = {sr[7:0], ser_in};
        frame_done    = ser_en && (bit_cnt == LAST_BIT);
        par_ok        = (even_par(sr_next[8:1]) == sr_next[0]);
        is_sync_frame = (sr_next == SYNC_FRAME);
    end

    // Framing FSM with shift register, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_HUNT;
            sr         <= '0;
            bit_cnt    <= '0;
            conf_cnt   <= '0;
            err_run    <= '0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            sync_seen  <= 1'b0;
            par_err    <= 1'b0;
            locked     <= 1'b0;
            err_cnt    <= 8'h00;
        end else begin
            data_valid <= 1'b0;
            sync_seen  <= 1'b0;
            par_err    <= 1'b0;
            if (ser_en) begin
                sr      <= sr_next;
                bit_cnt <= (bit_cnt == LAST_BIT) ? 4'd0 : bit_cnt + 4'd1;
                case (state)
                    ST_HUNT: begin
                        // Match on the bit that completes the pattern; the next
                        // valid bit starts a fresh frame
                        if (is_sync_frame) begin
                            bit_cnt  <= '0;
                            conf_cnt <= '0;
                            if (CONFIRM == 1) begin
                                state   <= ST_LOCKED;
                                locked  <= 1'b1;
                                err_run <= '0;
                            end else begin
                                state <= ST_VERIFY;
                            end
                        end
                    end
                    ST_VERIFY: begin
                        if (frame_done) begin
                            if (is_sync_frame) begin
                                sync_seen <= 1'b1;
                                conf_cnt  <= conf_cnt + 3'd1;
                                if (conf_cnt + 3'd1 >= VERIFY_SYNCS) begin
                                    state   <= ST_LOCKED;
                                    locked  <= 1'b1;
                                    err_run <= '0;
                                end
                            end else begin
                                state <= ST_HUNT;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (frame_done) begin
                            if (par_ok) begin
                                err_run <= '0;
                                if (sr_next[8:1] == SYNC_WORD) begin
                                    sync_seen <= 1'b1;
                                end else begin
                                    data_out   <= sr_next[8:1];
                                    data_valid <= 1'b1;
                                end
                            end else begin
                                par_err <= 1'b1;
                                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                                if (err_run + 4'd1 >= ERR_LIMIT_W) begin
                                    state   <= ST_HUNT;
                                    locked  <= 1'b0;
                                    err_run <= '0;
                                end else begin
                                    err_run <= err_run + 4'd1;
                                end
                            end
                        end
                    end
                    default: begin
                        state  <= ST_HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
